// File: rtl/pwm_motor_pkg.sv
// pwm_motor_pkg
// Shared definitions for the PWM motor array: the per-channel state encoding,
// the four register offsets above BASE_ADDR, and the bit positions inside the
// control register.
package pwm_motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_REVERSE = 3'd3,
        ST_BRAKE   = 3'd4
    } motor_state_t;

    localparam logic [1:0] OFS_SELECT  = 2'd0;
    localparam logic [1:0] OFS_TARGET  = 2'd1;
    localparam logic [1:0] OFS_CONTROL = 2'd2;
    localparam logic [1:0] OFS_STATUS  = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_BRAKE  = 2;

endpackage

// File: rtl/pwm_motor_channel.sv
// pwm_motor_channel
// One motor channel: holds its target/control registers, runs the
// IDLE/RAMP/HOLD/REVERSE/BRAKE state machine and produces a registered PWM bit.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   boundary        - one-cycle pulse on the tick where the shared counter wraps
//   counter_next    - value the shared PWM counter takes at this edge
//   wr_target       - write target duty from wr_data
//   wr_ctrl         - write enable/direction/brake from wr_data
//   wr_data         - processor write data
//   pwm, dir        - registered PWM output and applied direction
//   enable, brake   - current control bits (for status readback)
//   at_target       - cur_duty equals target
//   cur_duty, state - current duty and state (for readback)
module pwm_motor_channel
    import pwm_motor_pkg::*;
#(
    parameter int PWM_BITS  = 8,
    parameter int RAMP_STEP = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                boundary,
    input  logic [PWM_BITS-1:0] counter_next,
    input  logic                wr_target,
    input  logic                wr_ctrl,
    input  logic [7:0]          wr_data,
    output logic                pwm,
    output logic                dir,
    output logic                enable,
    output logic                brake,
    output logic                at_target,
    output logic [PWM_BITS-1:0] cur_duty,
    output motor_state_t        state
);

    // A step larger than full scale behaves like a jump straight to the goal.
    localparam int STEP_CLAMP = (RAMP_STEP >= (1 << PWM_BITS)) ? (1 << PWM_BITS) - 1 : RAMP_STEP;
    localparam logic [PWM_BITS:0]   STEP_GAP = (PWM_BITS+1)'(STEP_CLAMP);
    localparam logic [PWM_BITS-1:0] STEP_INC = PWM_BITS'(STEP_CLAMP);

    logic [PWM_BITS-1:0] target;
    logic                req_dir;
    motor_state_t        state_next;
    logic [PWM_BITS-1:0] duty_next;
    logic [PWM_BITS-1:0] ramp_val;
    logic [PWM_BITS-1:0] down_val;
    logic                dir_next;
    logic                pwm_next;
    logic                disable_now;
    logic                reversing;

    // Moves cur one step toward goal, landing exactly on goal when it is
    // within one step so a ramp never overshoots.
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] goal);
        logic [PWM_BITS:0]   gap;
        logic [PWM_BITS-1:0] result;
        if (cur < goal) begin
            gap    = {1'b0, goal} - {1'b0, cur};
            result = (gap <= STEP_GAP) ? goal : cur + STEP_INC;
        end else begin
            gap    = {1'b0, cur} - {1'b0, goal};
            result = (gap <= STEP_GAP) ? goal : cur - STEP_INC;
        end
        return result;
    endfunction

    // A disable write acts immediately; everything else waits for a boundary.
    assign disable_now = wr_ctrl && !wr_data[CTRL_ENABLE];
    assign reversing   = enable && !brake && (req_dir != dir);
    assign ramp_val    = step_toward(cur_duty, target);
    assign down_val    = step_toward(cur_duty, {PWM_BITS{1'b0}});
    assign at_target   = (cur_duty == target);

    // Processor-visible registers; the boundary logic sees their old values
    // when a write lands on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target  <= '0;
            enable  <= 1'b0;
            req_dir <= 1'b0;
            brake   <= 1'b0;
        end else begin
            if (wr_target) begin
                target <= wr_data[PWM_BITS-1:0];
            end
            if (wr_ctrl) begin
                enable  <= wr_data[CTRL_ENABLE];
                req_dir <= wr_data[CTRL_DIR];
                brake   <= wr_data[CTRL_BRAKE];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cur_duty <= '0;
            dir      <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            state    <= state_next;
            cur_duty <= duty_next;
            dir      <= dir_next;
            pwm      <= pwm_next;
        end
    end

    // Next state, evaluated in priority order disable > brake > reverse > ramp.
    always_comb begin
        state_next = state;
        if (disable_now) begin
            state_next = ST_IDLE;
        end else if (boundary) begin
            if (!enable) begin
                state_next = ST_IDLE;
            end else if (brake) begin
                state_next = ST_BRAKE;
            end else if (reversing) begin
                state_next = (down_val == '0) ? ST_RAMP : ST_REVERSE;
            end else begin
                state_next = (ramp_val == target) ? ST_HOLD : ST_RAMP;
            end
        end
    end

    // Duty/direction updates; pwm is computed from the values the counter and
    // duty take at this edge so the output lines up with the counter.
    always_comb begin
        duty_next = cur_duty;
        dir_next  = dir;
        if (disable_now) begin
            duty_next = '0;
        end else if (boundary) begin
            if (!enable || brake) begin
                duty_next = '0;
            end else if (reversing) begin
                duty_next = down_val;
                if (down_val == '0) begin
                    dir_next = req_dir;
                end
            end else begin
                duty_next = ramp_val;
            end
        end
        pwm_next = (counter_next < duty_next);
    end

endmodule

// File: rtl/pwm_motor_array.sv
// pwm_motor_array
// Array of NUM_CH ramped PWM motor channels behind a four-register processor
// port. The prescaler, PWM counter and register decode are shared here.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   port_id       - processor port address
//   out_port      - processor write data
//   write_strobe  - one-cycle write qualifier
//   rd_data       - registered read data for the address on port_id
//   pwm, dir      - per-channel registered PWM and applied direction
//   ramp_done     - every enabled channel sits at its target
module pwm_motor_array
    import pwm_motor_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         PWM_BITS  = 8,
    parameter int         PRESCALE  = 100,
    parameter int         RAMP_STEP = 4,
    parameter logic [7:0] BASE_ADDR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic [7:0]        out_port,
    input  logic              write_strobe,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] pwm,
    output logic [NUM_CH-1:0] dir,
    output logic              ramp_done
);

    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [3:0]      NUM_CH_W = 4'(NUM_CH);

    logic [PS_W-1:0]     prescale_cnt;
    logic                tick;
    logic                boundary;
    logic [PWM_BITS-1:0] counter;
    logic [PWM_BITS-1:0] counter_next;
    logic [2:0]          select;
    logic                addr_hit;
    logic [1:0]          offset;
    logic                sel_valid;
    logic                wr_sel;
    logic                wr_target;
    logic                wr_ctrl;
    logic [7:0]          rd_next;
    logic [PWM_BITS-1:0] sel_duty;
    logic [5:0]          sel_status;

    logic [PWM_BITS-1:0] ch_duty [NUM_CH];
    motor_state_t        ch_state [NUM_CH];
    logic [NUM_CH-1:0]   ch_enable;
    logic [NUM_CH-1:0]   ch_brake;
    logic [NUM_CH-1:0]   ch_at_target;

    assign tick         = (prescale_cnt == PS_LAST);
    assign counter_next = tick ? counter + 1'b1 : counter;
    assign boundary     = tick && (counter == '1);

    assign addr_hit  = (port_id[7:2] == BASE_ADDR[7:2]);
    assign offset    = port_id[1:0];
    assign sel_valid = ({1'b0, select} < NUM_CH_W);
    assign wr_sel    = write_strobe && addr_hit && (offset == OFS_SELECT);
    assign wr_target = write_strobe && addr_hit && (offset == OFS_TARGET) && sel_valid;
    assign wr_ctrl   = write_strobe && addr_hit && (offset == OFS_CONTROL) && sel_valid;

    // Prescaler, PWM counter, channel select and the ramp_done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_cnt <= '0;
            counter      <= '0;
            select       <= 3'd0;
            ramp_done    <= 1'b0;
            rd_data      <= 8'h00;
        end else begin
            prescale_cnt <= tick ? '0 : prescale_cnt + 1'b1;
            counter      <= counter_next;
            if (wr_sel) begin
                select <= out_port[2:0];
            end
            ramp_done <= &(ch_at_target | ~ch_enable);
            rd_data   <= rd_next;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_motor_channel #(
            .PWM_BITS  (PWM_BITS),
            .RAMP_STEP (RAMP_STEP)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .boundary     (boundary),
            .counter_next (counter_next),
            .wr_target    (wr_target && (select == 3'(i))),
            .wr_ctrl      (wr_ctrl && (select == 3'(i))),
            .wr_data      (out_port),
            .pwm          (pwm[i]),
            .dir          (dir[i]),
            .enable       (ch_enable[i]),
            .brake        (ch_brake[i]),
            .at_target    (ch_at_target[i]),
            .cur_duty     (ch_duty[i]),
            .state        (ch_state[i])
        );
    end

    // Readback of the selected channel; an out-of-range select reads as 0.
    always_comb begin
        sel_duty   = '0;
        sel_status = 6'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (select == 3'(i)) begin
                sel_duty   = ch_duty[i];
                sel_status = {ch_state[i], ch_brake[i], dir[i], ch_enable[i]};
            end
        end
    end

    always_comb begin
        rd_next = 8'h00;
        if (addr_hit) begin
            case (offset)
                OFS_SELECT:  rd_next = 8'(select);
                OFS_TARGET:  rd_next = 8'(sel_duty);
                OFS_CONTROL: rd_next = 8'(sel_status);
                OFS_STATUS:  rd_next = 8'(ch_at_target);
                default:     rd_next = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_motor_array.sv
// tb_pwm_motor_array
// Directed bench for pwm_motor_array with PRESCALE=1 so one PWM period is 256
// clocks. A table of register accesses covers decode and readback; hand
// sequences cover ramping, reversing, braking, full scale and reset.
module tb_pwm_motor_array;

    localparam int         NUM_CH    = 4;
    localparam int         PWM_BITS  = 8;
    localparam int         PRESCALE  = 1;
    localparam int         RAMP_STEP = 4;
    localparam logic [7:0] BASE      = 8'h20;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        port_id;
    logic [7:0]        out_port;
    logic              write_strobe;
    logic [7:0]        rd_data;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] dir;
    logic              ramp_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Independent model of the PWM counter (one tick per clock).
    logic [7:0] tb_cnt;

    typedef struct {
        logic       is_write;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] expect_rd;
    } vec_t;

    vec_t vecs [22];

    pwm_motor_array #(
        .NUM_CH    (NUM_CH),
        .PWM_BITS  (PWM_BITS),
        .PRESCALE  (PRESCALE),
        .RAMP_STEP (RAMP_STEP),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .rd_data      (rd_data),
        .pwm          (pwm),
        .dir          (dir),
        .ramp_done    (ramp_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= 8'd0;
        else       tb_cnt <= tb_cnt + 8'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
    endtask

    task automatic readReg(input logic [7:0] addr, output logic [7:0] data);
        @(negedge clk);
        port_id = addr;
        @(negedge clk);
        data    = rd_data;
        port_id = 8'h00;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [7:0] rd;
        if (v.is_write) begin
            writeReg(v.addr, v.data);
        end else begin
            readReg(v.addr, rd);
            checkOutput($sformatf("vec%0d_rd_%0h", idx, v.addr), 32'(rd), 32'(v.expect_rd));
        end
    endtask

    // Returns at the negedge just after the edge where the counter wrapped.
    task automatic waitBoundary();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tb_cnt != 8'd0 && guard < 300);
        if (tb_cnt != 8'd0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL boundary_wait: counter %0d, expected 0 within 300 cycles", tb_cnt);
        end
    endtask

    task automatic countHigh(input int ch, input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            if (pwm[ch]) highs++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         highs;
        int         any_high;
        logic [7:0] up_exp [4];
        logic [7:0] rev_duty [8];
        logic       rev_dir [8];

        up_exp   = '{8'd4, 8'd8, 8'd12, 8'd16};
        rev_duty = '{8'd12, 8'd8, 8'd4, 8'd0, 8'd4, 8'd8, 8'd12, 8'd16};
        rev_dir  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        vecs[0]  = '{1'b1, 8'h20, 8'h02, 8'h00};
        vecs[1]  = '{1'b0, 8'h20, 8'h00, 8'h02};
        vecs[2]  = '{1'b1, 8'h21, 8'h33, 8'h00};
        vecs[3]  = '{1'b0, 8'h21, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 8'h23, 8'h00, 8'h0B};
        vecs[5]  = '{1'b1, 8'h23, 8'hFF, 8'h00};
        vecs[6]  = '{1'b0, 8'h23, 8'h00, 8'h0B};
        vecs[7]  = '{1'b0, 8'h24, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 8'h1E, 8'h01, 8'h00};
        vecs[9]  = '{1'b0, 8'h22, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 8'h20, 8'h05, 8'h00};
        vecs[11] = '{1'b0, 8'h20, 8'h00, 8'h05};
        vecs[12] = '{1'b1, 8'h21, 8'hFF, 8'h00};
        vecs[13] = '{1'b1, 8'h22, 8'h07, 8'h00};
        vecs[14] = '{1'b0, 8'h23, 8'h00, 8'h0B};
        vecs[15] = '{1'b0, 8'h21, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 8'h22, 8'h00, 8'h00};
        vecs[17] = '{1'b1, 8'h20, 8'h02, 8'h00};
        vecs[18] = '{1'b1, 8'h21, 8'h00, 8'h00};
        vecs[19] = '{1'b0, 8'h23, 8'h00, 8'h0F};
        vecs[20] = '{1'b1, 8'h20, 8'h00, 8'h00};
        vecs[21] = '{1'b0, 8'h20, 8'h00, 8'h00};

        reset        = 1'b1;
        port_id      = 8'h00;
        out_port     = 8'h00;
        write_strobe = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_pwm", 32'(pwm), 32'h0);
        checkOutput("reset_dir", 32'(dir), 32'h0);
        checkOutput("reset_ramp_done", 32'(ramp_done), 32'h0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
        reset = 1'b0;

        $display("[TB] register decode table");
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i], i);
        end
        checkOutput("table_pwm_idle", 32'(pwm), 32'h0);
        checkOutput("table_dir_idle", 32'(dir), 32'h0);

        $display("[TB] ramp up channel 0 to 0x10");
        writeReg(BASE + 8'd1, 8'h10);
        writeReg(BASE + 8'd2, 8'h01);
        for (int i = 0; i < 4; i++) begin
            waitBoundary();
            readReg(BASE + 8'd1, rd);
            checkOutput($sformatf("ramp_up_%0d", i), 32'(rd), 32'(up_exp[i]));
        end
        checkOutput("ramp_up_done", 32'(ramp_done), 32'h1);
        readReg(BASE + 8'd2, rd);
        checkOutput("ramp_up_status", 32'(rd), 32'h11);
        countHigh(0, 256, highs);
        checkOutput("ramp_up_high_count", 32'(highs), 32'd16);
        checkOutput("other_pwm_low", 32'(pwm[3:1]), 32'h0);

        $display("[TB] reverse channel 0");
        writeReg(BASE + 8'd2, 8'h03);
        for (int i = 0; i < 8; i++) begin
            waitBoundary();
            checkOutput($sformatf("rev_dir_%0d", i), 32'(dir[0]), 32'(rev_dir[i]));
            readReg(BASE + 8'd1, rd);
            checkOutput($sformatf("rev_duty_%0d", i), 32'(rd), 32'(rev_duty[i]));
        end

        $display("[TB] ramp to 0x80 then brake");
        writeReg(BASE + 8'd1, 8'h80);
        repeat (28) waitBoundary();
        readReg(BASE + 8'd1, rd);
        checkOutput("hold_80_duty", 32'(rd), 32'h80);
        checkOutput("hold_80_done", 32'(ramp_done), 32'h1);
        writeReg(BASE + 8'd2, 8'h07);
        readReg(BASE + 8'd1, rd);
        checkOutput("brake_pre_boundary_duty", 32'(rd), 32'h80);
        waitBoundary();
        countHigh(0, 256, highs);
        checkOutput("brake_high_count", 32'(highs), 32'd0);
        readReg(BASE + 8'd1, rd);
        checkOutput("brake_duty", 32'(rd), 32'h0);
        checkOutput("brake_dir_held", 32'(dir[0]), 32'h1);
        readReg(BASE + 8'd2, rd);
        checkOutput("brake_status", 32'(rd), 32'h27);
        writeReg(BASE + 8'd2, 8'h03);
        waitBoundary();
        readReg(BASE + 8'd1, rd);
        checkOutput("unbrake_duty", 32'(rd), 32'h04);
        readReg(BASE + 8'd2, rd);
        checkOutput("unbrake_status", 32'(rd), 32'h0B);

        $display("[TB] full scale then disable");
        writeReg(BASE + 8'd1, 8'hFF);
        repeat (63) waitBoundary();
        readReg(BASE + 8'd1, rd);
        checkOutput("full_duty", 32'(rd), 32'hFF);
        countHigh(0, 256, highs);
        checkOutput("full_high_count", 32'(highs), 32'd255);
        writeReg(BASE + 8'd2, 8'h02);
        checkOutput("disable_pwm_next_cycle", 32'(pwm[0]), 32'h0);
        countHigh(0, 300, highs);
        checkOutput("disable_high_count", 32'(highs), 32'd0);
        readReg(BASE + 8'd1, rd);
        checkOutput("disable_duty", 32'(rd), 32'h0);
        checkOutput("disable_dir_held", 32'(dir[0]), 32'h1);

        $display("[TB] reset mid-ramp on channel 1");
        writeReg(BASE + 8'd0, 8'h01);
        writeReg(BASE + 8'd1, 8'h40);
        writeReg(BASE + 8'd2, 8'h01);
        waitBoundary();
        waitBoundary();
        countHigh(1, 256, highs);
        checkOutput("ch1_ramp_high_count", 32'(highs), 32'd8);
        port_id = BASE;
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_pwm1", 32'(pwm[1]), 32'h1);
        checkOutput("pre_reset_rd", 32'(rd_data), 32'h01);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_pwm", 32'(pwm), 32'h0);
        checkOutput("async_reset_dir", 32'(dir), 32'h0);
        checkOutput("async_reset_ramp_done", 32'(ramp_done), 32'h0);
        checkOutput("async_reset_rd", 32'(rd_data), 32'h0);
        port_id = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        any_high = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (pwm != '0) any_high++;
        end
        checkOutput("post_reset_no_pwm", 32'(any_high), 32'd0);
        readReg(BASE + 8'd0, rd);
        checkOutput("post_reset_select", 32'(rd), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
